// File: rtl/pong_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl_if
//   Signal bundle between the pong game sequencer and the rest of the VGA
//   pong datapath (button debouncer, pixel generator, text/score overlay).
//
//   refresh_tick  one-cycle pulse per frame (start of vertical retrace)
//   btn           debounced, clk-synchronous serve/start button level
//   ball_hit      one-cycle pulse, ball struck paddle
//   ball_miss     one-cycle pulse, ball passed right screen edge
//   graph_still   1 = pixel generator holds paddle/ball static
//   serve         one-cycle pulse, pixel generator reloads ball start
//   game_state    00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER
//   score_d1      BCD tens digit of the hit score
//   score_d0      BCD units digit of the hit score
//   lives         balls remaining
//
//   master: the game sequencer side
//   slave : the datapath / overlay side
// ---------------------------------------------------------------------------
interface pong_game_ctrl_if;
  logic       refresh_tick;
  logic       btn;
  logic       ball_hit;
  logic       ball_miss;
  logic       graph_still;
  logic       serve;
  logic [1:0] game_state;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [1:0] lives;

  modport master (
    input  refresh_tick, btn, ball_hit, ball_miss,
    output graph_still, serve, game_state, score_d1, score_d0, lives
  );

  modport slave (
    output refresh_tick, btn, ball_hit, ball_miss,
    input  graph_still, serve, game_state, score_d1, score_d0, lives
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
//   Game sequencer for the VGA pong datapath. Tracks NEWGAME / PLAY /
//   NEWBALL / OVER, freezes or releases the moving objects, pulses serve to
//   re-centre the ball, keeps a 2-digit BCD hit score and counts lives.
//
//   Parameters
//     LIVES         balls per game (1..3)
//     TIMER_FRAMES  frames of enforced pause after a miss (1..255)
//
//   Ports
//     clk    system pixel clock
//     reset  asynchronous, active-low reset (0 = reset asserted)
//     bus    master side of pong_game_ctrl_if (inputs from debouncer and
//            pixel generator, registered outputs to datapath and overlay)
// ---------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int TIMER_FRAMES = 120
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] TIMER_INIT = 8'(TIMER_FRAMES);

  state_t     state;
  state_t     state_next;
  logic       btn_q;
  logic       btn_rise;
  logic [7:0] timer;
  logic       timer_zero;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [1:0] lives;
  logic       graph_still;
  logic       serve;
  logic       graph_still_next;
  logic       serve_next;

  assign btn_rise   = bus.btn & ~btn_q;
  assign timer_zero = (timer == 8'd0);

  // State register; reset returns to NEWGAME regardless of clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= NEWGAME;
    else        state <= state_next;
  end

  // Next-state logic. Collision pulses only matter in PLAY and a miss takes
  // priority over a hit in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      NEWGAME: if (btn_rise) state_next = PLAY;
      PLAY: begin
        if (bus.ball_miss) begin
          if (lives == 2'd1) state_next = OVER;
          else               state_next = NEWBALL;
        end
      end
      NEWBALL: if (timer_zero && btn_rise) state_next = PLAY;
      OVER:    if (timer_zero) state_next = NEWGAME;
      default: state_next = NEWGAME;
    endcase
  end

  // Output decode, computed from the upcoming state so the registered
  // outputs line up with the state register: serve is high exactly in the
  // first cycle game_state reads PLAY.
  always_comb begin
    graph_still_next = (state_next != PLAY);
    serve_next       = (state_next == PLAY) && (state != PLAY);
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      graph_still <= 1'b1;
      serve       <= 1'b0;
    end else begin
      graph_still <= graph_still_next;
      serve       <= serve_next;
    end
  end

  // Datapath: button edge detector, BCD score, lives and pause timer.
  // btn_q resets to 1 so a button held through reset does not start a game.
  // A miss loads the timer even if refresh_tick arrives in the same cycle,
  // since PLAY never decrements it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q    <= 1'b1;
      timer    <= 8'd0;
      score_d1 <= 4'd0;
      score_d0 <= 4'd0;
      lives    <= LIVES_INIT;
    end else begin
      btn_q <= bus.btn;
      case (state)
        NEWGAME: begin
          lives <= LIVES_INIT;
          if (btn_rise) begin
            score_d1 <= 4'd0;
            score_d0 <= 4'd0;
          end
        end
        PLAY: begin
          if (bus.ball_miss) begin
            lives <= lives - 2'd1;
            timer <= TIMER_INIT;
          end else if (bus.ball_hit) begin
            if (score_d0 == 4'd9) begin
              score_d0 <= 4'd0;
              score_d1 <= (score_d1 == 4'd9) ? 4'd0 : score_d1 + 4'd1;
            end else begin
              score_d0 <= score_d0 + 4'd1;
            end
          end
        end
        NEWBALL: begin
          if (bus.refresh_tick && !timer_zero) timer <= timer - 8'd1;
        end
        OVER: begin
          if (bus.refresh_tick && !timer_zero) timer <= timer - 8'd1;
          if (timer_zero) lives <= LIVES_INIT;
        end
        default: ;
      endcase
    end
  end

  assign bus.graph_still = graph_still;
  assign bus.serve       = serve;
  assign bus.game_state  = state;
  assign bus.score_d1    = score_d1;
  assign bus.score_d0    = score_d0;
  assign bus.lives       = lives;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pong_game_ctrl
//   Directed, self-checking bench for pong_game_ctrl. Each checked step
//   pushes its expected outputs onto a scoreboard queue as the stimulus is
//   driven; the entry is popped and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_pong_game_ctrl;

  localparam int LIVES        = 3;
  localparam int TIMER_FRAMES = 120;

  localparam logic [1:0] NG = 2'b00;
  localparam logic [1:0] PL = 2'b01;
  localparam logic [1:0] NB = 2'b10;
  localparam logic [1:0] OV = 2'b11;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       still;
    logic       srv;
    int         score;
    logic [1:0] lv;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  pong_game_ctrl_if bus();

  exp_t sb[$];
  int   check_count = 0;
  int   pass_count  = 0;
  int   fail_count  = 0;
  int   exp_score;
  logic [1:0] exp_lives;

  pong_game_ctrl #(
    .LIVES        (LIVES),
    .TIMER_FRAMES (TIMER_FRAMES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running pixel clock, 10 time units per period.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    check_count++;
    assert (obs === expv) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pushExp(input string tag, input logic [1:0] st, input logic srv);
    exp_t e;
    e.tag   = tag;
    e.st    = st;
    e.still = (st != PL);
    e.srv   = srv;
    e.score = exp_score;
    e.lv    = exp_lives;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      check_count++;
      fail_count++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".state"}, {6'd0, bus.game_state}, {6'd0, e.st});
      cmp({e.tag, ".still"}, {7'd0, bus.graph_still}, {7'd0, e.still});
      cmp({e.tag, ".serve"}, {7'd0, bus.serve}, {7'd0, e.srv});
      cmp({e.tag, ".score"}, {bus.score_d1, bus.score_d0},
          {4'(e.score / 10), 4'(e.score % 10)});
      cmp({e.tag, ".lives"}, {6'd0, bus.lives}, {6'd0, e.lv});
    end
  endtask

  // One clock cycle of stimulus; pulses drop after the edge, btn is a level.
  task automatic applyStimulus(input logic hit, input logic miss, input logic tick,
                               input logic b, input bit chk, input string tag,
                               input logic [1:0] st, input logic srv);
    bus.ball_hit     = hit;
    bus.ball_miss    = miss;
    bus.refresh_tick = tick;
    bus.btn          = b;
    if (chk) pushExp(tag, st, srv);
    @(posedge clk);
    #1;
    bus.ball_hit     = 1'b0;
    bus.ball_miss    = 1'b0;
    bus.refresh_tick = 1'b0;
    if (chk) checkOutput();
  endtask

  initial begin
    bus.refresh_tick = 1'b0;
    bus.ball_hit     = 1'b0;
    bus.ball_miss    = 1'b0;
    bus.btn          = 1'b1;
    reset            = 1'b0;
    exp_score        = 0;
    exp_lives        = 2'(LIVES);

    // Reset values while reset is held with the button pressed.
    #12;
    pushExp("reset", NG, 1'b0);
    checkOutput();
    @(negedge clk);
    reset = 1'b1;

    // Button held through reset must not start a game.
    repeat (3) applyStimulus(0, 0, 0, 1, 1, "held_btn", NG, 0);
    applyStimulus(0, 0, 0, 0, 1, "btn_release", NG, 0);
    applyStimulus(0, 0, 0, 1, 1, "start", PL, 1);
    applyStimulus(0, 0, 0, 0, 1, "start_serve_off", PL, 0);

    // Twelve hits, each visible on the next edge.
    for (int i = 1; i <= 12; i++) begin
      exp_score = i;
      applyStimulus(1, 0, 0, 0, 1, "hit", PL, 0);
    end
    cmp("score12", {bus.score_d1, bus.score_d0}, 8'h12);

    // Run up to 99, then wrap to 00.
    for (int i = 13; i <= 99; i++) begin
      exp_score = i;
      applyStimulus(1, 0, 0, 0, (i == 99), "hit99", PL, 0);
    end
    exp_score = 0;
    applyStimulus(1, 0, 0, 0, 1, "wrap", PL, 0);

    // First miss, with a coincident refresh_tick that must not count.
    exp_lives = 2'd2;
    applyStimulus(0, 1, 1, 0, 1, "miss1", NB, 0);
    applyStimulus(0, 0, 0, 1, 1, "early_btn", NB, 0);
    applyStimulus(0, 0, 0, 0, 1, "early_rel", NB, 0);
    applyStimulus(1, 0, 0, 0, 1, "hit_in_nb", NB, 0);
    for (int i = 0; i < TIMER_FRAMES - 1; i++) applyStimulus(0, 0, 1, 0, 0, "", NB, 0);
    applyStimulus(0, 0, 0, 1, 1, "btn_timer1", NB, 0);
    applyStimulus(0, 0, 1, 0, 1, "last_tick", NB, 0);
    applyStimulus(0, 0, 0, 0, 1, "no_queue", NB, 0);
    applyStimulus(0, 0, 0, 1, 1, "serve_nb", PL, 1);
    applyStimulus(0, 0, 0, 0, 1, "serve_nb_off", PL, 0);

    // Score to 05, then a simultaneous hit and miss.
    for (int i = 1; i <= 5; i++) begin
      exp_score = i;
      applyStimulus(1, 0, 0, 0, 1, "hit5", PL, 0);
    end
    exp_lives = 2'd1;
    applyStimulus(1, 1, 0, 0, 1, "hit_miss", NB, 0);
    for (int i = 0; i < TIMER_FRAMES; i++) applyStimulus(0, 0, 1, 0, 0, "", NB, 0);
    applyStimulus(0, 0, 0, 1, 1, "serve2", PL, 1);
    applyStimulus(0, 0, 0, 0, 1, "serve2_off", PL, 0);

    // Last ball lost: OVER, countdown, then back to NEWGAME.
    exp_lives = 2'd0;
    applyStimulus(0, 1, 0, 0, 1, "miss_last", OV, 0);
    applyStimulus(0, 0, 0, 1, 1, "btn_in_over", OV, 0);
    applyStimulus(0, 0, 0, 0, 1, "rel_over", OV, 0);
    for (int i = 0; i < TIMER_FRAMES - 1; i++) applyStimulus(0, 0, 1, 0, 0, "", OV, 0);
    applyStimulus(0, 0, 1, 0, 1, "over_tick_last", OV, 0);
    exp_lives = 2'(LIVES);
    applyStimulus(0, 0, 0, 0, 1, "to_newgame", NG, 0);
    applyStimulus(1, 0, 0, 0, 1, "hit_in_ng", NG, 0);

    // New game clears the retained score.
    exp_score = 0;
    applyStimulus(0, 0, 0, 1, 1, "restart", PL, 1);
    applyStimulus(0, 0, 0, 0, 1, "restart_off", PL, 0);
    exp_lives = 2'd2;
    applyStimulus(0, 1, 0, 0, 1, "miss_r", NB, 0);
    for (int i = 0; i < 70; i++) applyStimulus(0, 0, 1, 0, 0, "", NB, 0);

    // Asynchronous reset mid-NEWBALL, checked before the next clock edge.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    exp_lives = 2'(LIVES);
    pushExp("async_reset", NG, 1'b0);
    checkOutput();
    bus.btn = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 1, 1, "post_reset_held", NG, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level game sequencer for the VGA pong datapath. It holds the game in one of four states: new game, play, new ball and game over. It freezes or releases the pixel generator's moving objects, issues the serve pulse that re-centres the ball, keeps a 2-digit BCD hit score and counts remaining lives. It sits between the debounced button inputs, the collision pulses from the pixel generator and the text/score overlay.

Parameters:
LIVES, 3, balls per game (1..3, held in 2-bit counter)
TIMER_FRAMES, 120, frames of enforced pause after a miss or game over (1..255, 8-bit timer); 120 frames = 2 s at 60 Hz

Ports:
clk  input  1  system pixel clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
refresh_tick  input  1  one-cycle pulse per frame (start of vertical retrace)
btn  input  1  debounced, clk-synchronous serve/start button level
ball_hit  input  1  one-cycle pulse, ball struck paddle
ball_miss  input  1  one-cycle pulse, ball passed right screen edge
graph_still  output  1  1 = pixel generator holds paddle/ball static
serve  output  1  one-cycle pulse, pixel generator reloads ball start position/velocity
game_state  output  2  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER
score_d1  output  4  BCD tens digit
score_d0  output  4  BCD units digit
lives  output  2  balls remaining

Behaviour:
- Reset (reset=0, async): state=NEWGAME, graph_still=1, serve=0, score=00, lives=LIVES, timer=0, btn_q=1.
- btn_q is reset to 1 so a button held through reset does not start a game.
- btn_rise = btn & ~btn_q; btn_q <= btn every clk.
- All outputs are registered. graph_still is 1 in every state except PLAY.
- NEWGAME:
  - lives held at LIVES; score holds its last value so the final score stays on display.
  - On btn_rise: go to PLAY, clear score to 00, load lives=LIVES, assert serve for exactly the first PLAY cycle.
- PLAY:
  - ball_hit: score +1 in BCD. d0 9->0 carries into d1. 99 wraps to 00 with no flag.
  - ball_miss: lives -1 and timer=TIMER_FRAMES.
    - If lives was 1: lives=0, go to OVER.
    - Else: go to NEWBALL.
  - ball_hit and ball_miss in the same cycle: miss wins and the hit is discarded (score unchanged).
  - btn is ignored.
- NEWBALL:
  - Timer decrements by 1 on each refresh_tick while nonzero; it never underflows below 0.
  - When timer==0 and btn_rise: go to PLAY and pulse serve.
  - btn_rise while timer!=0 is ignored and not queued.
  - ball_hit and ball_miss are ignored in every state other than PLAY.
- OVER:
  - Timer counts down as in NEWBALL.
  - On the cycle timer==0 is observed: go to NEWGAME (score retained, lives reloaded to LIVES on entry).
  - btn is ignored.
- Latency:
  - Any input pulse is reflected in the registered outputs on the next rising clk edge.
  - serve is high for the single cycle in which game_state first reads 01.
- refresh_tick coinciding with the state transition that loads the timer: the load wins and that tick is not counted.
- Reset asserted mid-game: immediate return to the reset values, independent of clk. Deassertion is synchronous to clk by the system reset synchroniser.

Test Plan:
- Reset with btn held high, then release and press again: no start while held; after release and a new press, game_state 00->01, serve high for exactly 1 cycle, score=00, lives=3.
- In PLAY, 12 ball_hit pulses: score_d1=1, score_d0=2. Preload to 99 via 99 hits, then 1 more hit: score=00.
- ball_miss with lives=3: lives=2, game_state=10, graph_still=1. Press btn before 120 refresh_ticks: no effect. After 120 ticks, press btn: game_state=01, serve pulses.
- ball_hit and ball_miss on the same cycle with score=05, lives=2: score stays 05, lives=1, state=10.
- Third miss: lives=0, state=11. After 120 refresh_ticks: state=00, lives=3, score keeps its final value until the next start clears it.
- Assert reset mid-NEWBALL with timer=50: outputs return to reset values asynchronously, before the next clk edge.
